// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver: prescaled digit scan, remappable commons,
// per-digit dp/blank/blink, leading-zero suppression, PWM and tear-free capture.
module seg_scan_driver #(
    parameter int          NUM_DIGITS     = 6,
    parameter int          COM_WIDTH      = 8,
    parameter logic [31:0] COM_MAP        = 32'h7632_1045,
    parameter int          SCAN_DIV       = 1000,
    parameter int          BLINK_DIV      = 250,
    parameter bit          COM_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    lz_blank,
    input  logic [3:0]              brightness,
    output logic [7:0]              seg_data,
    output logic [COM_WIDTH-1:0]    seg_com,
    output logic                    frame_tick
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int OW = PW + 5;
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [COM_WIDTH-1:0] COM_IDLE =
        COM_ACTIVE_LOW ? {COM_WIDTH{1'b1}} : {COM_WIDTH{1'b0}};

    logic [PW-1:0]           pres;
    logic [2:0]              slot;
    logic [FW-1:0]           fcnt;
    logic                    phase_on;
    logic [4*NUM_DIGITS-1:0] sh_digits;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_blank;
    logic [NUM_DIGITS-1:0]   sh_blink;
    logic                    sh_lz;
    logic [3:0]              sh_bright;

    logic                    pres_wrap;
    logic                    frame_start;
    logic                    frame_end;
    logic [OW-1:0]           on_len;
    logic                    com_on;
    logic [3:0]              cur_dig;
    logic                    cur_dp;
    logic                    cur_blank;
    logic                    cur_blink;
    logic                    cur_lz;
    logic                    all_zero;
    logic [COM_WIDTH-1:0]    cur_com;
    logic [7:0]              seg_next;
    logic [COM_WIDTH-1:0]    com_next;

    function automatic logic [7:0] hex_seg(input logic [3:0] d);
        logic [7:0] s;
        unique case (d)
            4'h0: s = 8'h3F;
            4'h1: s = 8'h06;
            4'h2: s = 8'h5B;
            4'h3: s = 8'h4F;
            4'h4: s = 8'h66;
            4'h5: s = 8'h6D;
            4'h6: s = 8'h7D;
            4'h7: s = 8'h07;
            4'h8: s = 8'h7F;
            4'h9: s = 8'h6F;
            4'hA: s = 8'h77;
            4'hB: s = 8'h7C;
            4'hC: s = 8'h39;
            4'hD: s = 8'h5E;
            4'hE: s = 8'h79;
            4'hF: s = 8'h71;
        endcase
        return s;
    endfunction

    assign pres_wrap   = (pres == PW'(SCAN_DIV - 1));
    assign frame_start = (slot == 3'(NUM_DIGITS - 1)) && (pres == '0);
    assign frame_end   = (slot == 3'd0) && pres_wrap;
    assign on_len      = ((OW'(sh_bright) + OW'(1)) * OW'(SCAN_DIV)) >> 4;
    assign com_on      = (pres != '0) && (OW'(pres) < on_len);

    // Select the shadow fields of the digit in the current slot; a digit is
    // lz-dark when it and every more significant digit are zero.
    always_comb begin
        cur_dig   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_blink = 1'b0;
        cur_lz    = 1'b0;
        cur_com   = COM_IDLE;
        all_zero  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero && (sh_digits[4*i +: 4] == 4'h0);
            if (slot == 3'(i)) begin
                cur_dig   = sh_digits[4*i +: 4];
                cur_dp    = sh_dp[i];
                cur_blank = sh_blank[i];
                cur_blink = sh_blink[i];
                cur_lz    = sh_lz && (i != 0) && all_zero;
                cur_com   = COM_IDLE ^ (COM_WIDTH'(1) << COM_MAP[4*i +: 4]);
            end
        end
    end

    // Segment/common value for this slot; dark outside the PWM on-window.
    always_comb begin
        seg_next = 8'h00;
        com_next = COM_IDLE;
        if (com_on) begin
            com_next = cur_com;
            if (cur_blank) begin
                seg_next = 8'h00;
            end else if (cur_blink && !phase_on) begin
                seg_next = 8'h00;
            end else if (cur_lz) begin
                seg_next = {cur_dp, 7'h00};
            end else begin
                seg_next = hex_seg(cur_dig) | {cur_dp, 7'h00};
            end
        end
    end

    // Prescaler and slot counter; scan runs from the MSB digit down.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pres <= '0;
            slot <= 3'(NUM_DIGITS - 1);
        end else begin
            pres <= pres_wrap ? '0 : pres + PW'(1);
            if (pres_wrap) begin
                slot <= (slot == 3'd0) ? 3'(NUM_DIGITS - 1) : slot - 3'd1;
            end
        end
    end

    // Shadow capture at frame start keeps a frame's content consistent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_digits <= '0;
            sh_dp     <= '0;
            sh_blank  <= '0;
            sh_blink  <= '0;
            sh_lz     <= 1'b0;
            sh_bright <= 4'h0;
        end else if (frame_start) begin
            sh_digits <= digits;
            sh_dp     <= dp_mask;
            sh_blank  <= blank_mask;
            sh_blink  <= blink_mask;
            sh_lz     <= lz_blank;
            sh_bright <= brightness;
        end
    end

    // Count completed frames; the phase flip lands on the next frame start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt     <= '0;
            phase_on <= 1'b1;
        end else if (frame_end) begin
            if (fcnt == FW'(BLINK_DIV - 1)) begin
                fcnt     <= '0;
                phase_on <= ~phase_on;
            end else begin
                fcnt <= fcnt + FW'(1);
            end
        end
    end

    // Registered pin drivers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_data   <= 8'h00;
            seg_com    <= COM_IDLE;
            frame_tick <= 1'b0;
        end else begin
            seg_data   <= seg_next;
            seg_com    <= com_next;
            frame_tick <= frame_start;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: cycle-level reference model from the display
// rules plus directed scenarios with fixed expected patterns.
module tb_seg_scan_driver;

    localparam int N  = 6;
    localparam int SD = 16;
    localparam int BD = 2;
    localparam int FL = N * SD;
    localparam logic [31:0] MAP = 32'h7632_1045;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [23:0]   digits = '0;
    logic [5:0]    dp_mask = '0;
    logic [5:0]    blank_mask = '0;
    logic [5:0]    blink_mask = '0;
    logic          lz_blank = 1'b0;
    logic [3:0]    brightness = 4'hF;
    logic [7:0]    seg_data;
    logic [7:0]    seg_com;
    logic          frame_tick;

    seg_scan_driver #(
        .NUM_DIGITS(N), .COM_WIDTH(8), .COM_MAP(MAP),
        .SCAN_DIV(SD), .BLINK_DIV(BD), .COM_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .digits(digits), .dp_mask(dp_mask),
        .blank_mask(blank_mask), .blink_mask(blink_mask),
        .lz_blank(lz_blank), .brightness(brightness),
        .seg_data(seg_data), .seg_com(seg_com), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    logic [7:0] hex7 [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D,
                              8'h7D, 8'h07, 8'h7F, 8'h6F, 8'h77, 8'h7C,
                              8'h39, 8'h5E, 8'h79, 8'h71};

    int checks = 0;
    int passed = 0;
    int ts = 0;
    int st, pres_m, slot_m, frame_m;

    logic [23:0] s_digits;
    logic [5:0]  s_dp, s_blank, s_blink;
    logic        s_lz;
    logic [3:0]  s_bright;
    logic [7:0]  exp_seg, exp_com;
    logic        exp_tick;

    // Advance one clock and compute what the display should show for the
    // cycle just processed (inputs are latched at every frame start).
    task automatic step();
        int on_len, pos;
        logic [23:0] rem;
        logic [7:0] dpv;
        if (ts % FL == 0) begin
            s_digits = digits; s_dp = dp_mask; s_blank = blank_mask;
            s_blink = blink_mask; s_lz = lz_blank; s_bright = brightness;
        end
        @(posedge clk); #1;
        st = ts;
        ts++;
        pres_m  = st % SD;
        slot_m  = N - 1 - (st / SD) % N;
        frame_m = st / FL;
        on_len  = ((int'(s_bright) + 1) * SD) / 16;
        exp_tick = (st % FL == 0);
        exp_seg = 8'h00;
        exp_com = 8'hFF;
        if (pres_m >= 1 && pres_m < on_len) begin
            pos = (MAP >> (4 * slot_m)) & 32'hF;
            exp_com = ~(8'h01 << pos);
            rem = s_digits >> (4 * slot_m);
            dpv = s_dp[slot_m] ? 8'h80 : 8'h00;
            if (s_blank[slot_m])
                exp_seg = 8'h00;
            else if (s_blink[slot_m] && ((frame_m / BD) % 2 == 1))
                exp_seg = 8'h00;
            else if (s_lz && slot_m != 0 && rem == 24'h0)
                exp_seg = dpv;
            else
                exp_seg = hex7[rem[3:0]] | dpv;
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ts = 0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({seg_com, seg_data, frame_tick} !== {8'hFF, 8'h00, 1'b0})
            $display("FAIL reset_init got %h/%h/%b want FF/00/0",
                     seg_com, seg_data, frame_tick);
        else passed++;
        digits = 24'h987654; brightness = 4'hF;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        ts = 0;
        step();
        checks++;
        if (frame_tick !== 1'b1)
            $display("FAIL reset_first_tick got %b want 1", frame_tick);
        else passed++;
        for (int i = 0; i < 24; i++) begin
            step();
            checks++;
            if ({seg_com, seg_data, frame_tick} !== {exp_com, exp_seg, exp_tick})
                $display("FAIL reset_run t=%0d got %h/%h/%b want %h/%h/%b", st,
                         seg_com, seg_data, frame_tick, exp_com, exp_seg, exp_tick);
            else passed++;
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({seg_com, seg_data, frame_tick} !== {8'hFF, 8'h00, 1'b0})
            $display("FAIL reset_async got %h/%h/%b want FF/00/0",
                     seg_com, seg_data, frame_tick);
        else passed++;
        @(posedge clk); #1;
        checks++;
        if ({seg_com, seg_data, frame_tick} !== {8'hFF, 8'h00, 1'b0})
            $display("FAIL reset_hold got %h/%h/%b want FF/00/0",
                     seg_com, seg_data, frame_tick);
        else passed++;
        rst = 1'b0;
        ts = 0;
        step();
        checks++;
        if (frame_tick !== 1'b1)
            $display("FAIL reset_restart_tick got %b want 1", frame_tick);
        else passed++;
        step();
        checks++;
        if (frame_tick !== 1'b0)
            $display("FAIL reset_tick_width got %b want 0", frame_tick);
        else passed++;
    endtask

    task automatic test_scan_order();
        logic [7:0] want_com [6] = '{8'hF7, 8'hFB, 8'hFD, 8'hFE, 8'hEF, 8'hDF};
        logic [7:0] want_seg [6] = '{8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D};
        int on_cnt;
        digits = 24'h123456; brightness = 4'hF;
        dp_mask = '0; blank_mask = '0; blink_mask = '0; lz_blank = 1'b0;
        apply_reset();
        on_cnt = 0;
        for (int i = 0; i < FL; i++) begin
            step();
            if (seg_com !== 8'hFF) on_cnt++;
            checks++;
            if ({seg_com, seg_data, frame_tick} !== {exp_com, exp_seg, exp_tick})
                $display("FAIL scan_model t=%0d got %h/%h/%b want %h/%h/%b", st,
                         seg_com, seg_data, frame_tick, exp_com, exp_seg, exp_tick);
            else passed++;
            if (pres_m == 8) begin
                checks++;
                if ({seg_com, seg_data} !== {want_com[st/SD], want_seg[st/SD]})
                    $display("FAIL scan_slot k=%0d got %h/%h want %h/%h", st / SD,
                             seg_com, seg_data, want_com[st/SD], want_seg[st/SD]);
                else passed++;
            end
            if (pres_m == 0) begin
                checks++;
                if ({seg_com, seg_data} !== {8'hFF, 8'h00})
                    $display("FAIL scan_dead t=%0d got %h/%h want FF/00",
                             st, seg_com, seg_data);
                else passed++;
            end
        end
        checks++;
        if (on_cnt !== 6 * 15)
            $display("FAIL scan_on_cycles got %0d want %0d", on_cnt, 6 * 15);
        else passed++;
    endtask

    task automatic test_pwm();
        int on_cnt;
        brightness = 4'd3;
        apply_reset();
        on_cnt = 0;
        for (int i = 0; i < FL; i++) begin
            step();
            if (seg_com !== 8'hFF) begin
                on_cnt++;
                checks++;
                if (pres_m < 1 || pres_m > 3)
                    $display("FAIL pwm_window pres=%0d got com %h want FF",
                             pres_m, seg_com);
                else passed++;
            end
            checks++;
            if ({seg_com, seg_data, frame_tick} !== {exp_com, exp_seg, exp_tick})
                $display("FAIL pwm_model t=%0d got %h/%h/%b want %h/%h/%b", st,
                         seg_com, seg_data, frame_tick, exp_com, exp_seg, exp_tick);
            else passed++;
        end
        checks++;
        if (on_cnt !== 6 * 3)
            $display("FAIL pwm_on_cycles got %0d want 18", on_cnt);
        else passed++;
        brightness = 4'hF;
    endtask

    task automatic test_leading_zero();
        logic [7:0] want_a [6] = '{8'h00, 8'h00, 8'h80, 8'h4F, 8'h3F, 8'h6D};
        logic [7:0] want_b [6] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3F};
        for (int pass = 0; pass < 2; pass++) begin
            lz_blank = 1'b1;
            digits  = (pass == 0) ? 24'h000305 : 24'h000000;
            dp_mask = (pass == 0) ? 6'b001000 : 6'b000000;
            apply_reset();
            for (int i = 0; i < FL; i++) begin
                step();
                checks++;
                if ({seg_com, seg_data, frame_tick} !== {exp_com, exp_seg, exp_tick})
                    $display("FAIL lz_model t=%0d got %h/%h/%b want %h/%h/%b", st,
                             seg_com, seg_data, frame_tick, exp_com, exp_seg, exp_tick);
                else passed++;
                if (pres_m == 8) begin
                    checks++;
                    if (seg_data !== ((pass == 0) ? want_a[st/SD] : want_b[st/SD]))
                        $display("FAIL lz_digit p=%0d k=%0d got %h want %h", pass,
                                 st / SD, seg_data,
                                 (pass == 0) ? want_a[st/SD] : want_b[st/SD]);
                    else passed++;
                end
            end
        end
        lz_blank = 1'b0; dp_mask = '0;
    endtask

    task automatic test_tear_free();
        digits = 24'h111111;
        apply_reset();
        for (int i = 0; i < 2 * FL; i++) begin
            step();
            if (st == 40) digits = 24'h222222;
            checks++;
            if ({seg_com, seg_data, frame_tick} !== {exp_com, exp_seg, exp_tick})
                $display("FAIL tear_model t=%0d got %h/%h/%b want %h/%h/%b", st,
                         seg_com, seg_data, frame_tick, exp_com, exp_seg, exp_tick);
            else passed++;
            if (pres_m == 8) begin
                checks++;
                if (seg_data !== ((st < FL) ? 8'h06 : 8'h5B))
                    $display("FAIL tear_slot t=%0d got %h want %h", st, seg_data,
                             (st < FL) ? 8'h06 : 8'h5B);
                else passed++;
            end
        end
    endtask

    task automatic test_blink_blank();
        logic [7:0] d0_seg;
        digits = 24'($urandom);
        d0_seg = hex7[digits[3:0]];
        blink_mask = 6'b000001; blank_mask = 6'b100000;
        apply_reset();
        for (int i = 0; i < 5 * FL; i++) begin
            step();
            checks++;
            if ({seg_com, seg_data, frame_tick} !== {exp_com, exp_seg, exp_tick})
                $display("FAIL blink_model t=%0d got %h/%h/%b want %h/%h/%b", st,
                         seg_com, seg_data, frame_tick, exp_com, exp_seg, exp_tick);
            else passed++;
            if (pres_m == 8 && slot_m == 0) begin
                checks++;
                if (seg_data !== ((frame_m == 2 || frame_m == 3) ? 8'h00 : d0_seg))
                    $display("FAIL blink_d0 f=%0d got %h want %h", frame_m, seg_data,
                             (frame_m == 2 || frame_m == 3) ? 8'h00 : d0_seg);
                else passed++;
            end
            if (pres_m == 8 && slot_m == 5) begin
                checks++;
                if (seg_data !== 8'h00)
                    $display("FAIL blank_d5 f=%0d got %h want 00", frame_m, seg_data);
                else passed++;
            end
        end
        blink_mask = '0; blank_mask = '0;
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 30 * FL; i++) begin
            step();
            checks++;
            if ({seg_com, seg_data, frame_tick} !== {exp_com, exp_seg, exp_tick})
                $display("FAIL rand_model t=%0d got %h/%h/%b want %h/%h/%b", st,
                         seg_com, seg_data, frame_tick, exp_com, exp_seg, exp_tick);
            else passed++;
            if ($urandom_range(0, 39) == 0) begin
                digits = 24'($urandom) >> $urandom_range(0, 24);
                dp_mask = 6'($urandom);
                blank_mask = 6'($urandom) & 6'($urandom);
                blink_mask = 6'($urandom);
                lz_blank = 1'($urandom);
                brightness = 4'($urandom);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_pwm();
        test_leading_zero();
        test_tear_free();
        test_blink_blank();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
